// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, FSM states, ALU codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } statetype;

endpackage

// File: rtl/mips_multicycle_controller_aludec.sv
// ALU decoder: aluop plus funct -> 3-bit alucontrol.
// Purely combinational, no state, no flow control.
module aludec
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore FSM sequencing a multicycle MIPS datapath with unified instruction/data memory.
// Latency: lw 5, sw/R/addi 4, beq/bne/j 3, illegal 2 cycles; outputs combinational from state.
// No backpressure: the datapath is assumed to complete every step in one cycle.
module mips_multicycle_controller
  import mips_pkg::*;
#(
  parameter logic EN_BNE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  statetype state, nextstate;
  // Variant bit captured in DECODE: sw (vs lw) or bne (vs beq), so op is not needed later.
  logic     alt_q, alt_d;
  logic     illegal_dec;
  logic     pcwrite, branch;
  aluop_t   aluop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      alt_q <= 1'b0;
    end else begin
      state <= nextstate;
      alt_q <= alt_d;
    end
  end

  always_comb begin
    nextstate   = FETCH;
    alt_d       = alt_q;
    illegal_dec = 1'b0;
    case (state)
      FETCH: nextstate = DECODE;
      DECODE: begin
        alt_d = (op == OP_SW) || (op == OP_BNE);
        case (op)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_RTYPE:     nextstate = EXECUTE;
          OP_BEQ:       nextstate = BRANCH;
          OP_BNE: begin
            if (EN_BNE) nextstate = BRANCH;
            else        illegal_dec = 1'b1;
          end
          OP_ADDI:      nextstate = ADDIEX;
          OP_J:         nextstate = JUMP;
          default:      illegal_dec = 1'b1;
        endcase
      end
      MEMADR:  nextstate = alt_q ? MEMWR : MEMRD;
      MEMRD:   nextstate = MEMWB;
      EXECUTE: nextstate = ALUWB;
      ADDIEX:  nextstate = ADDIWB;
      default: nextstate = FETCH;
    endcase
  end

  // Outputs are gated by reset so an aborted instruction cannot write anything.
  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    if (!reset) begin
      case (state)
        FETCH: begin
          alusrcb = 2'b01;
          irwrite = 1'b1;
          pcwrite = 1'b1;
        end
        DECODE:  alusrcb = 2'b11;
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD:   iord = 1'b1;
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        EXECUTE: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        ADDIWB:  regwrite = 1'b1;
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pcen    = pcwrite | (branch & (zero ^ alt_q));
  assign illegal = illegal_dec & ~reset;

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized bench for the multicycle controller: per-instruction cycle model, two DUTs (EN_BNE 0/1).
module tb_mips_multicycle_controller;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;
  localparam logic [15:0] RST_MASK = 16'hFFF1;

  logic       clk = 1'b0;
  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0;
  logic       act = 1'b0;

  logic       pcen0, memwrite0, irwrite0, regwrite0, iord0, memtoreg0, regdst0, alusrca0, illegal0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;
  logic       pcen1, memwrite1, irwrite1, regwrite1, iord1, memtoreg1, regdst1, alusrca1, illegal1;
  logic [1:0] alusrcb1, pcsrc1;
  logic [2:0] alucontrol1;
  logic [15:0] vec0, vec1, vec_a, vec_i;

  int vectors = 0, fails = 0, checks = 0;
  int mw_cnt = 0, rw_cnt = 0;
  int cur_k = 0, cur_c = 0;
  bit exp_valid = 1'b0;
  logic [15:0] exp_vec = '0;
  bit fresh = 1'b1;

  always #5 clk = ~clk;

  mips_multicycle_controller #(.EN_BNE(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen0), .memwrite(memwrite0), .irwrite(irwrite0), .regwrite(regwrite0),
    .iord(iord0), .memtoreg(memtoreg0), .regdst(regdst0), .alusrca(alusrca0),
    .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0), .illegal(illegal0)
  );

  mips_multicycle_controller #(.EN_BNE(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen1), .memwrite(memwrite1), .irwrite(irwrite1), .regwrite(regwrite1),
    .iord(iord1), .memtoreg(memtoreg1), .regdst(regdst1), .alusrca(alusrca1),
    .alusrcb(alusrcb1), .pcsrc(pcsrc1), .alucontrol(alucontrol1), .illegal(illegal1)
  );

  assign vec0 = {pcen0, memwrite0, irwrite0, regwrite0, iord0, memtoreg0, regdst0, alusrca0,
                 alusrcb0, pcsrc0, alucontrol0, illegal0};
  assign vec1 = {pcen1, memwrite1, irwrite1, regwrite1, iord1, memtoreg1, regdst1, alusrca1,
                 alusrcb1, pcsrc1, alucontrol1, illegal1};
  assign vec_a = act ? vec1 : vec0;
  assign vec_i = act ? vec0 : vec1;

  function automatic logic [2:0] fn_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int ilen(input int k, input bit en);
    case (k)
      K_LW:                return 5;
      K_SW, K_R, K_ADDI:   return 4;
      K_BEQ, K_J:          return 3;
      K_BNE:               return en ? 3 : 2;
      default:             return 2;
    endcase
  endfunction

  // Expected outputs in cycle c of an instruction of kind k, cycle 0 being its fetch.
  function automatic logic [15:0] model(input int k, input int c, input bit en,
                                        input logic z, input logic [5:0] f);
    logic pc, mw, irw, rw, io, m2r, rd, asa, il;
    logic [1:0] asb, ps;
    logic [2:0] alu;
    {pc, mw, irw, rw, io, m2r, rd, asa, il} = '0;
    asb = 2'b00;
    ps  = 2'b00;
    alu = 3'b010;
    if (c == 0) begin
      pc = 1'b1; irw = 1'b1; asb = 2'b01;
    end else if (c == 1) begin
      asb = 2'b11;
      il  = (k == K_ILL) || (k == K_BNE && !en);
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (c == 2) begin asa = 1'b1; asb = 2'b10; end
          else if (c == 3) begin io = 1'b1; mw = (k == K_SW); end
          else begin rw = 1'b1; m2r = 1'b1; end
        end
        K_R: begin
          if (c == 2) begin asa = 1'b1; alu = fn_alu(f); end
          else begin rd = 1'b1; rw = 1'b1; end
        end
        K_ADDI: begin
          if (c == 2) begin asa = 1'b1; asb = 2'b10; end
          else rw = 1'b1;
        end
        K_BEQ, K_BNE: begin
          asa = 1'b1; alu = 3'b110; ps = 2'b01;
          pc  = (k == K_BEQ) ? z : ~z;
        end
        K_J: begin pc = 1'b1; ps = 2'b10; end
        default: ;
      endcase
    end
    return {pc, mw, irw, rw, io, m2r, rd, asa, asb, ps, alu, il};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [5:0] op_of(input int k);
    logic [5:0] o;
    case (k)
      K_LW:   o = 6'b100011;
      K_SW:   o = 6'b101011;
      K_R:    o = 6'b000000;
      K_ADDI: o = 6'b001000;
      K_BEQ:  o = 6'b000100;
      K_BNE:  o = 6'b000101;
      K_J:    o = 6'b000010;
      default: begin
        do o = 6'($urandom);
        while (o == 6'd0 || o == 6'd2 || o == 6'd4 || o == 6'd5 ||
               o == 6'd8 || o == 6'd35 || o == 6'd43);
      end
    endcase
    return o;
  endfunction

  // Compare process: active DUT against the model, idle DUT must sit silent in reset.
  always @(negedge clk) begin
    #2;
    check("idle_in_reset", vec_i & RST_MASK, 16'h0000);
    if (exp_valid) begin
      check($sformatf("model k%0d c%0d bne%0d", cur_k, cur_c, act), vec_a, exp_vec);
      mw_cnt += int'(vec_a[14]);
      rw_cnt += int'(vec_a[12]);
    end
  end

  task automatic run_instr(input int k, input logic [5:0] opc, input logic [5:0] fn,
                           input logic zb, input int cut);
    int n;
    n = ilen(k, act);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      if (act) rst1 = 1'b0; else rst0 = 1'b0;
      op    = (c == 1) ? opc : 6'($urandom);
      funct = (c == 2 && k == K_R) ? fn : 6'($urandom);
      zero  = (c == 2) ? zb : 1'($urandom);
      cur_k = k;
      cur_c = c;
      exp_vec   = model(k, c, act, zb, fn);
      exp_valid = 1'b1;
      vectors++;
      #2;
      if (c == 0 && fresh) begin
        check("first_fetch irw/pcen/asb", {12'h000, vec_a[13], vec_a[15], vec_a[7:6]}, 16'h000D);
        fresh = 1'b0;
      end
      if (k == K_ILL && c == 1)
        check("illegal_pulse", {15'h0000, vec_a[0]}, 16'h0001);
      if (c == cut) begin
        exp_valid = 1'b0;
        if (act) rst1 = 1'b1; else rst0 = 1'b1;
        #1;
        check("reset_async_outputs", vec_a & RST_MASK, 16'h0000);
        check("reset_async_memwrite", {15'h0000, vec_a[14]}, 16'h0000);
        fresh = 1'b1;
        break;
      end
    end
    if (cut < 0) begin
      @(posedge clk);
      exp_valid = 1'b0;
    end
  endtask

  task automatic reset_hold_check();
    @(posedge clk);
    #1;
    check("reset_held_outputs", vec_a & RST_MASK, 16'h0000);
  endtask

  task automatic run_phase();
    logic [5:0] fn_tab [5];
    fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    run_instr(K_LW,   op_of(K_LW),   6'h00, 1'b0, -1);
    mw_cnt = 0; rw_cnt = 0;
    run_instr(K_SW,   op_of(K_SW),   6'h00, 1'b0, -1);
    check("sw_memwrite_cycles", 16'(mw_cnt), 16'd1);
    check("sw_regwrite_cycles", 16'(rw_cnt), 16'd0);
    run_instr(K_R,    op_of(K_R),    6'b101010, 1'b0, -1);
    run_instr(K_BEQ,  op_of(K_BEQ),  6'h00, 1'b1, -1);
    run_instr(K_BEQ,  op_of(K_BEQ),  6'h00, 1'b0, -1);
    run_instr(K_BNE,  op_of(K_BNE),  6'h00, 1'b0, -1);
    run_instr(K_BNE,  op_of(K_BNE),  6'h00, 1'b1, -1);
    run_instr(K_ILL,  6'b111111,     6'h00, 1'b0, -1);
    run_instr(K_ADDI, op_of(K_ADDI), 6'h00, 1'b0, -1);
    run_instr(K_J,    op_of(K_J),    6'h00, 1'b0, -1);
    run_instr(K_SW,   op_of(K_SW),   6'h00, 1'b0, 3);
    reset_hold_check();
    for (int i = 0; i < 150; i++) begin
      int k, cut;
      logic [5:0] fn;
      k   = $urandom_range(0, 7);
      fn  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ilen(k, act) - 1) : -1;
      run_instr(k, op_of(k), fn, 1'($urandom), cut);
      if (cut >= 0) reset_hold_check();
    end
  endtask

  initial begin
    act = 1'b0;
    run_phase();
    @(posedge clk);
    #1;
    rst0 = 1'b1;
    act  = 1'b1;
    fresh = 1'b1;
    run_phase();
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
